// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/ready/valid handshake and status flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 111); otherwise op 111 raises err.
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic               ready,
  output logic               valid,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               ovf,
  output logic               err
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  op_e              opc;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] r1;
  logic             c1;
  logic             v1;

  assign opc = op_e'(op);

  // Single-cycle datapath; dif_ext[WIDTH] is set exactly when a < b + cin (borrow).
  always_comb begin
    sum_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    dif_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    r1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    case (opc)
      OP_ADD: begin
        r1 = sum_ext[WIDTH-1:0];
        c1 = sum_ext[WIDTH];
        v1 = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        r1 = dif_ext[WIDTH-1:0];
        c1 = dif_ext[WIDTH];
        v1 = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: r1 = a & b;
      OP_OR:  r1 = a | b;
      OP_XOR: r1 = a ^ b;
      OP_SHL: begin
        r1 = {a[WIDTH-2:0], cin};
        c1 = a[WIDTH-1];
      end
      OP_SHR: begin
        r1 = {cin, a[WIDTH-1:1]};
        c1 = a[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  assign ready    = (state == S_IDLE);
  assign err      = 1'b0;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      valid  <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (opc == OP_MUL) begin
              mcand  <= {{WIDTH{1'b0}}, a};
              mplier <= b;
              acc    <= '0;
              count  <= '0;
              state  <= S_MUL;
            end else begin
              valid  <= 1'b1;
              result <= {{WIDTH{1'b0}}, r1};
              carry  <= c1;
              zero   <= (r1 == '0);
              ovf    <= v1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          // Last iteration publishes the combinational sum so no extra cycle is spent.
          if (count == CW'(WIDTH - 1)) begin
            result <= acc_next;
            valid  <= 1'b1;
            carry  <= 1'b0;
            zero   <= (acc_next == '0);
            ovf    <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign ready = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        valid <= 1'b1;
        if (opc == OP_MUL) begin
          result <= '0;
          carry  <= 1'b0;
          zero   <= 1'b1;
          ovf    <= 1'b0;
          err    <= 1'b1;
        end else begin
          result <= {{WIDTH{1'b0}}, r1};
          carry  <= c1;
          zero   <= (r1 == '0);
          ovf    <= v1;
          err    <= 1'b0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8); exercises MUL when ALU_MUL_EN is defined, else the err path.
module tb_alu_seq;
  localparam int unsigned W = 8;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   a, b;
  logic           cin;
  logic           ready, valid, carry, zero, ovf, err;
  logic [2*W-1:0] result;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .ready(ready), .valid(valid), .result(result), .carry(carry), .zero(zero),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*W-1:0] result;
    logic           carry;
    logic           zero;
    logic           ovf;
    logic           err;
  } exp_t;

  exp_t        scb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic c);
    exp_t e;
    int   s, ss;
    int   sx, sy;
    e  = '0;
    sx = int'($signed(x));
    sy = int'($signed(y));
    s  = 0;
    case (o)
      ADD: begin
        s  = int'(x) + int'(y) + int'(c);
        ss = sx + sy + int'(c);
        e.carry = (s > 255);
        e.ovf   = (ss > 127) || (ss < -128);
        s = s & 255;
      end
      SUB: begin
        s  = int'(x) - int'(y) - int'(c);
        ss = sx - sy - int'(c);
        e.carry = (s < 0);
        e.ovf   = (ss > 127) || (ss < -128);
        s = s & 255;
      end
      AND_: s = int'(x & y);
      OR_:  s = int'(x | y);
      XOR_: s = int'(x ^ y);
      SHL: begin
        s = ((int'(x) * 2) + int'(c)) & 255;
        e.carry = x[W-1];
      end
      SHR: begin
        s = (int'(c) * 128) + (int'(x) / 2);
        e.carry = x[0];
      end
      default: begin
`ifdef ALU_MUL_EN
        s = int'(x) * int'(y);
`else
        s = 0;
        e.err = 1'b1;
`endif
      end
    endcase
    e.result = s[2*W-1:0];
    e.zero   = (s[2*W-1:0] == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      check_eq("sb_nonempty", 64'(scb.size() != 0), 1);
      if (scb.size() != 0) begin
        e = scb.pop_front();
        check_eq("result", result, e.result);
        check_eq("carry",  carry,  e.carry);
        check_eq("zero",   zero,   e.zero);
        check_eq("ovf",    ovf,    e.ovf);
        check_eq("err",    err,    e.err);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c);
    int t = 0;
    if (!ready) start = 1'b0;
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check_eq("ready_timeout", ready, 1);
      return;
    end
    op = o; a = x; b = y; cin = c; start = 1'b1;
    scb.push_back(model(o, x, y, c));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int t = 0;
    while (!valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq(tag, valid, 1);
  endtask

  initial begin
    int t;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready",  ready,  1);
    check_eq("rst_valid",  valid,  0);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags",  {carry, zero, ovf, err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(ADD, 8'hFF, 8'h01, 1'b0);
    check_eq("add_ff_valid", valid, 1);
    check_eq("add_ff_res",   {result, carry, zero, ovf}, {16'h0000, 3'b110});
    issue(ADD, 8'h7F, 8'h01, 1'b0);
    check_eq("add_7f_res",   {result, ovf}, {16'h0080, 1'b1});
    issue(SUB, 8'h80, 8'h01, 1'b0);
    check_eq("sub_80_res",   {result, carry, ovf}, {16'h007F, 2'b01});
    issue(SHL, 8'h81, 8'h00, 1'b1);
    check_eq("shl_81_res",   {result, carry}, {16'h0003, 1'b1});
    issue(SUB, 8'h00, 8'h01, 1'b0);
    check_eq("sub_borrow",   {result, carry}, {16'h00FF, 1'b1});
    issue(ADD, 8'h7F, 8'h00, 1'b1);
    check_eq("add_cin_ovf",  {result, ovf}, {16'h0080, 1'b1});
    issue(SHR, 8'h81, 8'h00, 1'b1);
    check_eq("shr_81_res",   {result, carry}, {16'h00C0, 1'b1});
    repeat (3) @(negedge clk);
    check_eq("hold_valid",   valid, 0);
    check_eq("hold_result",  result, 16'h00C0);

    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
    @(negedge clk);

`ifdef ALU_MUL_EN
    issue(MUL, 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < int'(W); i++) begin
      check_eq("mul_busy_ready", ready, 0);
      check_eq("mul_busy_valid", valid, 0);
      if (i < int'(W) - 1) begin
        op = ADD; a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("mul_done_valid", valid, 1);
    check_eq("mul_done_ready", ready, 1);
    check_eq("mul_ff_res",     {result, zero}, {16'hFE01, 1'b0});
    issue(ADD, 8'h01, 8'h01, 1'b0);
    check_eq("add_after_mul",  {valid, result}, {1'b1, 16'h0002});

    issue(MUL, 8'hFF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready",  ready, 1);
    check_eq("midrst_outs",   {valid, result, carry, zero, ovf, err}, 0);
    scb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(MUL, 8'h03, 8'h05, 1'b0);
    wait_valid("mul_3x5_valid");
    check_eq("mul_3x5_res", result, 16'h000F);
    @(negedge clk);
`else
    issue(MUL, 8'h12, 8'h34, 1'b0);
    check_eq("nomul_valid", valid, 1);
    check_eq("nomul_res",   {result, zero, err}, {16'h0000, 2'b11});
    check_eq("nomul_ready", ready, 1);
    issue(AND_, 8'hF0, 8'h3C, 1'b0);
    check_eq("and_res",     {result, err}, {16'h0030, 1'b0});
`endif

    t = 0;
    while (scb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("sb_drained", scb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
